// File: rtl/m_edge_event_sender.sv
// Debounced per-channel edge detector: one-cycle event pulses, sticky
// pending flags and saturating per-channel event counters with a readout mux.
module m_edge_event_sender #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [WIDTH-1:0]                              in,
  input  logic [WIDTH-1:0]                              mode_rise,
  input  logic [WIDTH-1:0]                              mode_fall,
  output logic [WIDTH-1:0]                              out,
  output logic [WIDTH-1:0]                              pend,
  input  logic [WIDTH-1:0]                              pend_clr,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]  cnt_sel,
  output logic [CNT_W-1:0]                              cnt_val,
  input  logic                                          cnt_clr
);

  localparam int unsigned SEL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DCNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

  logic [WIDTH-1:0]  filt_q, filt_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic [DCNT_W-1:0] dcnt_q [WIDTH];
  logic [DCNT_W-1:0] dcnt_d [WIDTH];
  logic [CNT_W-1:0]  cnt_q  [WIDTH];
  logic [CNT_W-1:0]  cnt_d  [WIDTH];

  // Debounce: a changed input must persist DEBOUNCE sampling edges before filt follows.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      dcnt_d[i] = '0;
      if (DEBOUNCE == 0) begin
        filt_d[i] = in[i];
      end else if (in[i] == filt_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DCNT_MAX) begin
        filt_d[i] = in[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
      end
    end
    prev_d = filt_q;
  end

  // Edge events are combinational so mode changes act in the same cycle.
  assign out = (filt_q & ~prev_q & mode_rise) | (~filt_q & prev_q & mode_fall);

  // A new event wins over a simultaneous clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | out;
  end

  // Saturating counters; cnt_clr coinciding with an event leaves the count at 1.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = out[i] ? CNT_W'(1) : '0;
      end else if (out[i] && (cnt_q[i] != CNT_SAT)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Readout mux; unmatched selector values read as zero.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_val = cnt_q[i];
      end
    end
  end

  assign pend = pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        dcnt_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      filt_q <= filt_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        dcnt_q[i] <= dcnt_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule
